// File: rtl/oric_sdram_pkg.sv
// Shared types and constants for the Oric RAM bus to SDRAM port bridge.
package oric_sdram_pkg;

  localparam int ORIC_ADDR_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bridge_state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  typedef struct packed {
    logic [ORIC_ADDR_W-1:0] a;
    logic                   we;
    logic [7:0]             d;
  } pend_t;

  // Writes touch only the addressed byte lane; reads always fetch the whole word.
  function automatic logic [1:0] lane_sel(input logic we, input logic a0);
    if (!we) return DS_BOTH;
    return a0 ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/oric_access_detect.sv
// Spots the start of each new core access and presents the payload to capture.
module oric_access_detect #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_ad,
  input  logic [7:0]        ram_d,
  input  logic              ram_cs,
  input  logic              ram_oe,
  input  logic              ram_we,
  output logic              trigger,
  output logic [ADDR_W-1:0] cap_a,
  output logic              cap_we,
  output logic [7:0]        cap_d
);

  logic              rd_now;
  logic              wr_now;
  logic              rd_d;
  logic              wr_d;
  logic [ADDR_W-1:0] ad_d;

  assign rd_now = ram_cs & ram_oe;
  assign wr_now = ram_cs & ram_we;

  // Remember last cycle's strobes and address so edges and address moves can be seen.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_d <= 1'b0;
      wr_d <= 1'b0;
      ad_d <= '0;
    end else begin
      rd_d <= rd_now;
      wr_d <= wr_now;
      ad_d <= ram_ad;
    end
  end

  // A held read strobe with a moving address (video fetch) counts as a new access.
  assign trigger = (rd_now & ~rd_d) | (wr_now & ~wr_d) | (rd_now & (ram_ad != ad_d));
  assign cap_a   = ram_ad;
  assign cap_we  = wr_now;
  assign cap_d   = ram_d;

endmodule

// File: rtl/oric_sdram_bridge.sv
// Oric byte RAM bus to 16-bit toggle-handshake SDRAM port, with one pending slot.
module oric_sdram_bridge
  import oric_sdram_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_ad,
  input  logic [7:0]        ram_d,
  input  logic              ram_cs,
  input  logic              ram_oe,
  input  logic              ram_we,
  output logic [7:0]        ram_q,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-1:0] port_a,
  output logic [1:0]        port_ds,
  output logic              port_we,
  output logic [15:0]       port_d,
  input  logic [15:0]       port_q,
  output logic              busy,
  output logic              timeout,
  output logic [7:0]        overrun_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  bridge_state_t     state;
  logic              trigger;
  logic [ADDR_W-1:0] cap_a;
  logic              cap_we;
  logic [7:0]        cap_d;
  pend_t             cap_e;
  pend_t             pend;
  logic              pend_valid;
  pend_t             issue_e;
  logic              issue;
  logic              ack_match;
  logic              drop_pend;
  logic [7:0]        d_r;
  logic [7:0]        q_r;
  logic [CNT_W-1:0]  wait_cnt;

  oric_access_detect #(.ADDR_W(ADDR_W)) u_detect (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ram_ad  (ram_ad),
    .ram_d   (ram_d),
    .ram_cs  (ram_cs),
    .ram_oe  (ram_oe),
    .ram_we  (ram_we),
    .trigger (trigger),
    .cap_a   (cap_a),
    .cap_we  (cap_we),
    .cap_d   (cap_d)
  );

  assign cap_e     = '{a: cap_a, we: cap_we, d: cap_d};
  assign ack_match = (port_ack == port_req);

  // Decide whether to issue this cycle and from where; a fresh trigger beats a pending entry.
  always_comb begin
    issue   = 1'b0;
    issue_e = cap_e;
    if (state == IDLE) begin
      issue = trigger;
    end else if (ack_match) begin
      if (trigger) begin
        issue = 1'b1;
      end else if (pend_valid) begin
        issue   = 1'b1;
        issue_e = pend;
      end
    end
  end

  // Any trigger in WAIT while the slot is full loses an access, whether or not this is the ack cycle.
  assign drop_pend = (state == WAIT) && trigger && pend_valid;

  // Handshake FSM, capture registers, pending slot, read latch and status counters.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      port_req    <= 1'b0;
      port_a      <= '0;
      port_we     <= 1'b0;
      d_r         <= 8'h00;
      q_r         <= 8'h00;
      pend        <= '0;
      pend_valid  <= 1'b0;
      wait_cnt    <= '0;
      timeout     <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      if (issue) begin
        port_a   <= issue_e.a;
        port_we  <= issue_e.we;
        d_r      <= issue_e.d;
        port_req <= ~port_req;
        wait_cnt <= '0;
        state    <= WAIT;
      end else if (state == WAIT && ack_match) begin
        state <= IDLE;
      end else if (state == WAIT && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == WAIT && ack_match && !port_we) begin
        q_r <= port_a[0] ? port_q[15:8] : port_q[7:0];
      end

      if (state == WAIT && ack_match) begin
        pend_valid <= 1'b0;
      end else if (state == WAIT && trigger) begin
        pend       <= cap_e;
        pend_valid <= 1'b1;
      end

      if (drop_pend && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end

      if (state == WAIT && wait_cnt == CNT_MAX) begin
        timeout <= 1'b1;
      end
    end
  end

  assign busy    = (state == WAIT);
  assign port_ds = lane_sel(port_we, port_a[0]);
  assign port_d  = {d_r, d_r};
  assign ram_q   = ram_cs ? q_r : 8'h00;

endmodule
